// File: rtl/regfile_hw_if.sv
// Processor read/write bus plus hardware-update channels and tap window for regfile_hw.
interface regfile_hw_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_HW     = 3,
  parameter int unsigned NUM_TAP    = 4
);
  logic                           ctrl_writeEnable;
  logic [ADDR_WIDTH-1:0]          ctrl_writeReg;
  logic [DATA_WIDTH-1:0]          data_writeReg;
  logic [ADDR_WIDTH-1:0]          ctrl_readRegA;
  logic [ADDR_WIDTH-1:0]          ctrl_readRegB;
  logic [DATA_WIDTH-1:0]          data_readRegA;
  logic [DATA_WIDTH-1:0]          data_readRegB;
  logic [NUM_HW-1:0]              hw_we;
  logic [NUM_HW*DATA_WIDTH-1:0]   hw_data;
  logic [NUM_HW-1:0]              hw_ack;
  logic [NUM_HW*DATA_WIDTH-1:0]   hw_q;
  logic [NUM_HW-1:0]              hw_pending;
  logic [NUM_HW-1:0]              hw_overrun;
  logic [NUM_TAP*DATA_WIDTH-1:0]  tap_q;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output ctrl_readRegA, ctrl_readRegB,
    output hw_we, hw_data, hw_ack,
    input  data_readRegA, data_readRegB,
    input  hw_q, hw_pending, hw_overrun, tap_q
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  ctrl_readRegA, ctrl_readRegB,
    input  hw_we, hw_data, hw_ack,
    output data_readRegA, data_readRegB,
    output hw_q, hw_pending, hw_overrun, tap_q
  );
endinterface

// File: rtl/regfile_hw.sv
// Register file with two read ports, one processor write port, strided hardware-update
// channels with sticky pending/overrun flags, optional write bypass and a tap window.
module regfile_hw #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_HW     = 3,
  parameter int unsigned HW_BASE    = 20,
  parameter int unsigned HW_STRIDE  = 2,
  parameter int unsigned NUM_TAP    = 4,
  parameter int unsigned TAP_BASE   = 14,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  regfile_hw_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  // Channel number owning register idx, or -1 when no channel maps there.
  function automatic int ch_of(int unsigned idx);
    for (int unsigned k = 0; k < NUM_HW; k++) begin
      if (HW_BASE + k * HW_STRIDE == idx) return int'(k);
    end
    return -1;
  endfunction

  function automatic bit cfg_ok();
    if (NUM_HW < 1 || NUM_HW > 8) return 1'b0;
    if (TAP_BASE + NUM_TAP > DEPTH) return 1'b0;
    for (int unsigned k = 0; k < NUM_HW; k++) begin
      if (HW_BASE + k * HW_STRIDE == 0 || HW_BASE + k * HW_STRIDE >= DEPTH) return 1'b0;
      for (int unsigned j = 0; j < k; j++) begin
        if (HW_BASE + j * HW_STRIDE == HW_BASE + k * HW_STRIDE) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  if (!cfg_ok()) begin : g_cfg_err
    $error("regfile_hw: invalid channel or tap configuration");
  end

  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_nxt;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] rd_view;
  logic [NUM_HW-1:0]                pend_q;
  logic [NUM_HW-1:0]                ovr_q;
  logic [NUM_HW-1:0]                pend_nxt;
  logic [NUM_HW-1:0]                ovr_nxt;

  // Per-register next value; a hardware write beats the processor on the same index.
  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_reg
    localparam int CH = ch_of(i);
    if (i == 0) begin : g_zero
      assign regs_nxt[i] = '0;
    end else if (CH >= 0) begin : g_hw
      logic proc_hit;
      assign proc_hit    = bus.ctrl_writeEnable && (bus.ctrl_writeReg == ADDR_WIDTH'(i));
      assign regs_nxt[i] = bus.hw_we[CH] ? bus.hw_data[CH*DATA_WIDTH +: DATA_WIDTH]
                         : proc_hit      ? bus.data_writeReg
                         :                 regs_q[i];
    end else begin : g_cpu
      logic proc_hit;
      assign proc_hit    = bus.ctrl_writeEnable && (bus.ctrl_writeReg == ADDR_WIDTH'(i));
      assign regs_nxt[i] = proc_hit ? bus.data_writeReg : regs_q[i];
    end
  end

  // A new event stays pending even when acked on the same edge; ack always clears overrun.
  for (genvar k = 0; k < int'(NUM_HW); k++) begin : g_flag
    assign pend_nxt[k] = bus.hw_we[k] | (pend_q[k] & ~bus.hw_ack[k]);
    assign ovr_nxt[k]  = ~bus.hw_ack[k] & (ovr_q[k] | (bus.hw_we[k] & pend_q[k]));
    assign bus.hw_q[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[HW_BASE + k*HW_STRIDE];
  end

  for (genvar t = 0; t < int'(NUM_TAP); t++) begin : g_tap
    assign bus.tap_q[t*DATA_WIDTH +: DATA_WIDTH] = regs_q[TAP_BASE + t];
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      regs_q <= '0;
      pend_q <= '0;
      ovr_q  <= '0;
    end else begin
      regs_q <= regs_nxt;
      pend_q <= pend_nxt;
      ovr_q  <= ovr_nxt;
    end
  end

  // Bypass view already carries the write winner; reset forces reads to zero.
  assign rd_view           = BYPASS ? regs_nxt : regs_q;
  assign bus.data_readRegA = ctrl_reset ? '0 : rd_view[bus.ctrl_readRegA];
  assign bus.data_readRegB = ctrl_reset ? '0 : rd_view[bus.ctrl_readRegB];
  assign bus.hw_pending    = pend_q;
  assign bus.hw_overrun    = ovr_q;
endmodule

// File: tb/tb_regfile_hw.sv
// Scoreboard bench for regfile_hw: default configuration with a behavioural model, plus a
// narrow no-bypass configuration checked against constant expectations.
module tb_regfile_hw;
  localparam int DW = 32, AW = 5, NH = 3, HB = 20, HS = 2, NT = 4, TB = 14, DEPTH = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_hw_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_HW(NH), .NUM_TAP(NT)) bus_a ();
  regfile_hw_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4),  .NUM_HW(2),  .NUM_TAP(4))  bus_b ();

  regfile_hw #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_HW(NH), .HW_BASE(HB), .HW_STRIDE(HS),
               .NUM_TAP(NT), .TAP_BASE(TB), .BYPASS(1'b1))
    u_a (.clock(clk), .ctrl_reset(rst), .bus(bus_a.slave));

  regfile_hw #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .NUM_HW(2), .HW_BASE(8), .HW_STRIDE(1),
               .NUM_TAP(4), .TAP_BASE(12), .BYPASS(1'b0))
    u_b (.clock(clk), .ctrl_reset(rst), .bus(bus_b.slave));

  typedef struct {
    logic [DW-1:0]    rda;
    logic [DW-1:0]    rdb;
    logic [NH*DW-1:0] hwq;
    logic [NH-1:0]    pend;
    logic [NH-1:0]    ovr;
    logic [NT*DW-1:0] tap;
  } exp_a_t;

  typedef struct {
    logic [15:0] rda;
    logic [31:0] hwq;
  } exp_b_t;

  exp_a_t qa[$];
  exp_b_t qb[$];
  int n_chk = 0;
  int n_fail = 0;

  // Stimulus for the default configuration and its reference state
  logic             we;
  logic [AW-1:0]    wr, ra, rb;
  logic [DW-1:0]    wd;
  logic [NH-1:0]    hwe, ack;
  logic [NH*DW-1:0] hwd;
  logic [DW-1:0]    mem [DEPTH];
  logic [NH-1:0]    pend_m, ovr_m;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Value register idx holds after the coming edge: processor write, then channel writes win.
  function automatic logic [DW-1:0] next_val(int idx);
    logic [DW-1:0] v;
    if (idx == 0) return '0;
    v = mem[idx];
    if (we && int'(wr) == idx) v = wd;
    for (int k = 0; k < NH; k++)
      if (hwe[k] && HB + k*HS == idx) v = hwd[k*DW +: DW];
    return v;
  endfunction

  task automatic apply_a();
    bus_a.ctrl_writeEnable = we;
    bus_a.ctrl_writeReg    = wr;
    bus_a.data_writeReg    = wd;
    bus_a.ctrl_readRegA    = ra;
    bus_a.ctrl_readRegB    = rb;
    bus_a.hw_we            = hwe;
    bus_a.hw_data          = hwd;
    bus_a.hw_ack           = ack;
  endtask

  task automatic tick_a();
    exp_a_t e;
    logic [DW-1:0] nm [DEPTH];
    logic [NH-1:0] np, no;
    apply_a();
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      pend_m = '0;
      ovr_m  = '0;
    end
    e.rda = rst ? '0 : next_val(int'(ra));
    e.rdb = rst ? '0 : next_val(int'(rb));
    for (int k = 0; k < NH; k++) e.hwq[k*DW +: DW] = mem[HB + k*HS];
    for (int t = 0; t < NT; t++) e.tap[t*DW +: DW] = mem[TB + t];
    e.pend = pend_m;
    e.ovr  = ovr_m;
    qa.push_back(e);
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) nm[i] = next_val(i);
      np = pend_m;
      no = ovr_m;
      for (int k = 0; k < NH; k++) begin
        if (hwe[k]) begin
          np[k] = 1'b1;
          if (ack[k]) no[k] = 1'b0;
          else if (pend_m[k]) no[k] = 1'b1;
        end else if (ack[k]) begin
          np[k] = 1'b0;
          no[k] = 1'b0;
        end
      end
      for (int i = 0; i < DEPTH; i++) mem[i] = nm[i];
      pend_m = np;
      ovr_m  = no;
    end
    #1;
  endtask

  task automatic idle_a();
    we = 1'b0; hwe = '0; ack = '0;
  endtask

  task automatic tick_b(logic [15:0] rda, logic [31:0] hwq);
    exp_b_t e;
    e.rda = rda;
    e.hwq = hwq;
    qb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares whatever the DUTs present against the queued expectations.
  initial begin
    exp_a_t ea;
    exp_b_t eb;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        chk("rd_a",     128'(bus_a.data_readRegA), 128'(ea.rda));
        chk("rd_b",     128'(bus_a.data_readRegB), 128'(ea.rdb));
        chk("hw_q",     128'(bus_a.hw_q),          128'(ea.hwq));
        chk("pending",  128'(bus_a.hw_pending),    128'(ea.pend));
        chk("overrun",  128'(bus_a.hw_overrun),    128'(ea.ovr));
        chk("tap_q",    128'(bus_a.tap_q),         128'(ea.tap));
      end
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        chk("cfg_b_rd_a", 128'(bus_b.data_readRegA), 128'(eb.rda));
        chk("cfg_b_hw_q", 128'(bus_b.hw_q),          128'(eb.hwq));
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle_a();
    wr = '0; wd = '0; ra = '0; rb = '0; hwd = '0;
    pend_m = '0; ovr_m = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    apply_a();
    bus_b.ctrl_writeEnable = 1'b0; bus_b.ctrl_writeReg = '0; bus_b.data_writeReg = '0;
    bus_b.ctrl_readRegA = '0; bus_b.ctrl_readRegB = '0;
    bus_b.hw_we = '0; bus_b.hw_data = '0; bus_b.hw_ack = '0;
    @(posedge clk); #1;

    tick_a(); tick_a();
    rst = 1'b0;
    // Reset asserted between edges while a write is pending
    we = 1'b1; wr = 5'd5; wd = 32'hDEADBEEF; ra = 5'd5; rb = 5'd0; tick_a();
    idle_a(); tick_a();
    rst = 1'b1; we = 1'b1; wd = 32'hCAFEF00D; tick_a();
    rst = 1'b0; idle_a(); tick_a();
    // Register 0 ignores writes
    we = 1'b1; wr = 5'd0; wd = 32'h1234; ra = 5'd0; rb = 5'd0; tick_a();
    idle_a(); tick_a();
    // Basic writes, bypass and tap
    we = 1'b1; wr = 5'd7;  wd = 32'hA5A5A5A5; ra = 5'd7; tick_a();
    we = 1'b1; wr = 5'd14; wd = 32'h5A; rb = 5'd14; tick_a();
    idle_a(); tick_a();
    // Collision on reg 22 with channel 1
    we = 1'b1; wr = 5'd22; wd = 32'h11; hwe = 3'b010; hwd = '0; hwd[DW +: DW] = 32'h99;
    ra = 5'd22; rb = 5'd22; tick_a();
    idle_a(); tick_a();
    ack = 3'b010; tick_a();
    // Overrun on channel 0, then ack
    idle_a(); hwe = 3'b001; hwd[0 +: DW] = 32'h1; ra = 5'd20; tick_a();
    hwd[0 +: DW] = 32'h2; tick_a();
    idle_a(); tick_a();
    ack = 3'b001; tick_a();
    idle_a(); tick_a();
    // Channel 2: write, then write together with ack
    hwe = 3'b100; hwd[2*DW +: DW] = 32'h0BAD0001; ra = 5'd24; tick_a();
    tick_a();
    hwe = 3'b100; ack = 3'b100; hwd[2*DW +: DW] = 32'h0BAD0002; tick_a();
    idle_a(); tick_a();

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      we  = 1'($urandom_range(0, 1));
      wr  = ($urandom_range(0, 3) == 0) ? AW'(HB + HS * int'($urandom_range(0, NH-1))) : AW'($urandom);
      wd  = $urandom;
      hwe = NH'($urandom) & NH'($urandom);
      hwd = {$urandom, $urandom, $urandom};
      ack = ($urandom_range(0, 3) == 0) ? NH'($urandom) : '0;
      ra  = $urandom_range(0, 1) ? AW'($urandom) : wr;
      rb  = $urandom_range(0, 1) ? AW'(HB + HS * int'($urandom_range(0, NH-1))) : AW'($urandom);
      tick_a();
    end
    rst = 1'b0; idle_a(); tick_a();

    // No-bypass configuration: reads show the stored value only
    rst = 1'b1; apply_a(); @(posedge clk); #1; rst = 1'b0;
    bus_b.ctrl_writeEnable = 1'b1; bus_b.ctrl_writeReg = 4'd3; bus_b.data_writeReg = 16'hBEEF;
    bus_b.ctrl_readRegA = 4'd3;
    tick_b(16'h0000, 32'h0);
    bus_b.ctrl_writeEnable = 1'b0; bus_b.hw_we = 2'b10; bus_b.hw_data = 32'h7777_0000;
    tick_b(16'hBEEF, 32'h0);
    bus_b.hw_we = 2'b00; bus_b.ctrl_readRegA = 4'd9;
    tick_b(16'h7777, 32'h7777_0000);
    bus_b.ctrl_readRegA = 4'd8;
    tick_b(16'h0000, 32'h7777_0000);

    for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
    #1;
    if (qa.size() > 0 || qb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain pending=%0d required=0", qa.size() + qb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_hw.md
Name: regfile_hw

Overview:
- Parametrised successor to the processor register file. Provides R read ports 2, W write port 1, register 0 hardwired to zero.
- Adds NUM_HW hardware-update channels mapped onto a strided set of registers, used by button, screen and collision style I/O.
- Each channel carries sticky pending and overrun flags with an acknowledge-to-clear handshake.
- Provides optional write-to-read bypass and a parametrised contiguous tap window exported to the display logic.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register index width; DEPTH = 2**ADDR_WIDTH.
- NUM_HW, 3, number of hardware-update channels (1..8).
- HW_BASE, 20, register index of channel 0.
- HW_STRIDE, 2, index spacing between channels; channel k maps to HW_BASE + k*HW_STRIDE.
- NUM_TAP, 4, number of registers exported on tap_q.
- TAP_BASE, 14, first exported register index.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads show stored value only.

Ports:
- clock  in  1  rising-edge clock.
- ctrl_reset  in  1  asynchronous, active-high reset; clears all registers and flags.
- ctrl_writeEnable  in  1  processor write strobe.
- ctrl_writeReg  in  ADDR_WIDTH  processor write index.
- data_writeReg  in  DATA_WIDTH  processor write data.
- ctrl_readRegA  in  ADDR_WIDTH  read port A index.
- ctrl_readRegB  in  ADDR_WIDTH  read port B index.
- data_readRegA  out  DATA_WIDTH  read port A data, combinational.
- data_readRegB  out  DATA_WIDTH  read port B data, combinational.
- hw_we  in  NUM_HW  per-channel hardware write strobe.
- hw_data  in  NUM_HW*DATA_WIDTH  per-channel write data; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- hw_ack  in  NUM_HW  per-channel pending/overrun clear strobe from the processor side.
- hw_q  out  NUM_HW*DATA_WIDTH  current contents of each channel register.
- hw_pending  out  NUM_HW  sticky flag: channel written by hardware since last ack.
- hw_overrun  out  NUM_HW  sticky flag: hardware write arrived while pending was already set.
- tap_q  out  NUM_TAP*DATA_WIDTH  contents of registers TAP_BASE .. TAP_BASE+NUM_TAP-1.

Behaviour:
- Reset:
  - ctrl_reset high clears every register, hw_pending and hw_overrun to 0 immediately, without waiting for a clock edge.
  - All outputs read 0 while reset is held.
- Register 0:
  - Never written by either source.
  - Always reads 0, including on the bypass path.
- Processor write:
  - On a rising edge with ctrl_writeEnable=1, reg[ctrl_writeReg] <= data_writeReg.
  - One-cycle latency to the stored value.
- Hardware write:
  - On a rising edge with hw_we[k]=1, the channel-k register <= hw_data[k].
  - In the same edge, hw_pending[k] <= 1.
- Collision, same register on the same edge: the hardware write wins and the processor write to that index is dropped.
  - No effect on other indices.
- Flag update per channel, on each edge:
  - hw_we=1 and ack=1: pending=1; overrun is cleared. The new event stays pending.
  - hw_we=1, ack=0, pending already 1: overrun <= 1.
  - hw_we=0, ack=1: pending <= 0, overrun <= 0.
  - Otherwise: hold.
- Reads:
  - data_readRegX = reg[ctrl_readRegX] combinationally.
  - With BYPASS=1, if the index matches a write committing on the next edge, the read returns that incoming value. The effective winner (hardware over processor) is used.
  - With BYPASS=0, reads return the stored value.
  - Both ports may address the same register.
- Taps and channel outputs:
  - tap_q and hw_q always show stored values, never bypassed.
  - A tap window overlapping a channel register is legal.
- Configuration checks:
  - Elaboration fails if any channel index is 0 or >= DEPTH.
  - Elaboration fails if TAP_BASE+NUM_TAP > DEPTH.
  - Elaboration fails if two channels map to the same index.
- Reset mid-operation: asynchronous reset overrides any same-cycle write or ack. After deassertion, the first edge behaves normally.
- Implementation: one always block, posedge clock or posedge ctrl_reset. Read muxes are combinational. No tristate buses.

Test Plan:
- Reset and register 0:
  - Write 0xDEADBEEF to reg 5, then assert ctrl_reset between edges -> reg 5 reads 0 immediately.
  - Write 0x1234 to reg 0 -> both ports read 0.
- Basic read/write:
  - Write 0xA5A5A5A5 to reg 7 and 0x5A to reg 14.
  - -> Port A(7) = 0xA5A5A5A5, port B(14) = 0x5A, tap_q[0] = 0x5A.
  - With BYPASS=1, port A(7) shows 0xA5A5A5A5 in the write cycle itself.
- Collision:
  - Processor writes 0x11 to reg 22 while hw_we[1]=1 with hw_data=0x99 on the same edge -> reg 22 = 0x99 and hw_pending[1]=1.
  - In the same cycle, with BYPASS=1, the read of 22 returns 0x99.
- Overrun:
  - hw_we[0] pulses on two consecutive edges without ack -> pending=1, overrun=1.
  - Ack for one cycle -> both flags 0 on the next edge.
- Simultaneous hardware write and ack:
  - hw_we[2]=1 and hw_ack[2]=1 with pending already 1 -> pending=1, overrun=0, hw_q[2] = new data.
- Parameter sweep:
  - Configuration DATA_WIDTH=16, ADDR_WIDTH=4, NUM_HW=2, HW_BASE=8, HW_STRIDE=1, BYPASS=0.
  - Write reg 3 = 0xBEEF -> read of 3 in the write cycle returns the old value 0, and the next cycle returns 0xBEEF.
  - Channel 1 updates reg 9.
